// File: rtl/serdes_pkg.sv
// Shared types and elaboration helpers for the multi-lane serial transmitter.
package serdes_pkg;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // "SDR" -> 1 bit per cycle, anything else ("DDR") -> 2 bits per cycle.
  function automatic int unsigned bpc_of(input logic [23:0] rate);
    return (rate == "SDR") ? 1 : 2;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/serdes_lane_shifter.sv
// One lane: loads a WIDTH-bit word and emits BPC bits per cycle on a registered oq.
module serdes_lane_shifter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BPC       = 2,
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic        INIT_OQ   = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] ld_data,
  output logic [BPC-1:0]   oq
);

  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] sr;

  // Normalise to LSB-first so the shifter always drains from bit 0;
  // within a DDR pair bit 0 (rise) is therefore the earlier bit.
  always_comb begin
    src = ld_data;
    if (MSB_FIRST) begin
      for (int unsigned i = 0; i < WIDTH; i++) src[i] = ld_data[WIDTH-1-i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oq <= {BPC{INIT_OQ}};
      sr <= '0;
    end else if (ld) begin
      oq <= src[BPC-1:0];
      sr <= src >> BPC;
    end else if (sh) begin
      oq <= sr[BPC-1:0];
      sr <= sr >> BPC;
    end else begin
      oq <= {BPC{INIT_OQ}};
    end
  end

endmodule

// File: rtl/serdes_tx_lanes.sv
// Multi-lane SDR/DDR parallel-to-serial transmitter with hold-register double buffering.
// Optional idle training pattern enabled by defining SERDES_TX_TRAIN_EN.
module serdes_tx_lanes
  import serdes_pkg::*;
#(
  parameter int unsigned      LANES         = 2,
  parameter int unsigned      WIDTH         = 8,
  parameter                   DATA_RATE     = "DDR",
  parameter bit               MSB_FIRST     = 1'b0,
  parameter logic             INIT_OQ       = 1'b0,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'hB8
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*WIDTH-1:0]               in_data,
  output logic [LANES*bpc_of(DATA_RATE)-1:0]   oq,
  output logic                                 oq_valid,
  output logic                                 tq,
  output logic                                 busy
`ifdef SERDES_TX_TRAIN_EN
  ,
  input  logic                                 train_en
`endif
);

  localparam int unsigned   BPC   = bpc_of(DATA_RATE);
  localparam int unsigned   BEATS = WIDTH / BPC;
  localparam int unsigned   CW    = cnt_w(BEATS);
  // Counter holds beats already emitted; it reaches BEATS (mod 2^CW) on the last beat.
  localparam logic [CW-1:0] LAST  = CW'(BEATS);

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [LANES*WIDTH-1:0] hold;
  logic                   hold_full, hold_full_n;
  logic                   acc, take, last, train_req;
  logic                   lane_ld, lane_sh, ld_pat;
  logic                   ovalid_n, tq_n;

`ifdef SERDES_TX_TRAIN_EN
  assign train_req = train_en;
`else
  assign train_req = 1'b0;
`endif

  assign last        = (state == ST_SHIFT) && (cnt == LAST);
  assign take        = hold_full && ((state == ST_IDLE) || last);
  assign in_ready    = ~hold_full | take;
  assign acc         = in_valid & in_ready;
  assign busy        = hold_full | (state == ST_SHIFT);
  assign hold_full_n = acc | (hold_full & ~take);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      oq_valid  <= 1'b0;
      tq        <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hold_full <= hold_full_n;
      oq_valid  <= ovalid_n;
      tq        <= tq_n;
      if (acc) hold <= in_data;
    end
  end

  // A training word occupies SHIFT like data but with oq_valid low, so a
  // pending word can only be taken at its last beat, i.e. the pattern boundary.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ovalid_n = oq_valid;
    tq_n     = tq;
    lane_ld  = 1'b0;
    lane_sh  = 1'b0;
    ld_pat   = 1'b0;
    if (take) begin
      lane_ld  = 1'b1;
      state_n  = ST_SHIFT;
      cnt_n    = CW'(1);
      ovalid_n = 1'b1;
      tq_n     = 1'b0;
    end else if (train_req && ((state == ST_IDLE) || last)) begin
      lane_ld  = 1'b1;
      ld_pat   = 1'b1;
      state_n  = ST_SHIFT;
      cnt_n    = CW'(1);
      ovalid_n = 1'b0;
      tq_n     = 1'b0;
    end else if ((state == ST_SHIFT) && !last) begin
      lane_sh  = 1'b1;
      cnt_n    = cnt + CW'(1);
    end else begin
      state_n  = ST_IDLE;
      cnt_n    = '0;
      ovalid_n = 1'b0;
      tq_n     = 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    serdes_lane_shifter #(
      .WIDTH     (WIDTH),
      .BPC       (BPC),
      .MSB_FIRST (MSB_FIRST),
      .INIT_OQ   (INIT_OQ)
    ) u_lane (
      .CLK     (CLK),
      .RST     (RST),
      .ld      (lane_ld),
      .sh      (lane_sh),
      .ld_data (ld_pat ? TRAIN_PATTERN : hold[k*WIDTH +: WIDTH]),
      .oq      (oq[k*BPC +: BPC])
    );
  end

endmodule

// File: tb/tb_serdes_tx_lanes.sv
// Directed self-checking bench: SDR, DDR multi-lane, BEATS=1 streaming, backpressure, async reset.
module tb_serdes_tx_lanes;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // SDR, 1 lane, WIDTH 8, LSB first, idle 0
  logic       s_valid, s_ready, s_oqv, s_tq, s_busy;
  logic [7:0] s_data;
  logic [0:0] s_oq;
  // DDR, 2 lanes, WIDTH 8, MSB first, idle 1
  logic        d_valid, d_ready, d_oqv, d_tq, d_busy;
  logic [15:0] d_data;
  logic [3:0]  d_oq;
  // DDR, 1 lane, WIDTH 2 (BEATS=1), MSB first
  logic       b_valid, b_ready, b_oqv, b_tq, b_busy;
  logic [1:0] b_data;
  logic [1:0] b_oq;

`ifdef SERDES_TX_TRAIN_EN
  logic s_train = 1'b0;
  logic t_off   = 1'b0;
`endif

  serdes_tx_lanes #(
    .LANES(1), .WIDTH(8), .DATA_RATE("SDR"), .MSB_FIRST(1'b0), .INIT_OQ(1'b0), .TRAIN_PATTERN(8'hB8)
  ) u_sdr (
    .CLK(CLK), .RST(RST), .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data),
    .oq(s_oq), .oq_valid(s_oqv), .tq(s_tq), .busy(s_busy)
`ifdef SERDES_TX_TRAIN_EN
    , .train_en(s_train)
`endif
  );

  serdes_tx_lanes #(
    .LANES(2), .WIDTH(8), .DATA_RATE("DDR"), .MSB_FIRST(1'b1), .INIT_OQ(1'b1), .TRAIN_PATTERN(8'hB8)
  ) u_ddr (
    .CLK(CLK), .RST(RST), .in_valid(d_valid), .in_ready(d_ready), .in_data(d_data),
    .oq(d_oq), .oq_valid(d_oqv), .tq(d_tq), .busy(d_busy)
`ifdef SERDES_TX_TRAIN_EN
    , .train_en(t_off)
`endif
  );

  serdes_tx_lanes #(
    .LANES(1), .WIDTH(2), .DATA_RATE("DDR"), .MSB_FIRST(1'b1), .INIT_OQ(1'b0), .TRAIN_PATTERN(2'b10)
  ) u_b1 (
    .CLK(CLK), .RST(RST), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .oq(b_oq), .oq_valid(b_oqv), .tq(b_tq), .busy(b_busy)
`ifdef SERDES_TX_TRAIN_EN
    , .train_en(t_off)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // seq holds the serial bits in time order, first bit at seq[7]
  task automatic send_sdr(input string tag, input logic [7:0] word, input logic [7:0] seq);
    @(negedge CLK);
    chk({tag, "_ready"}, 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = word;
    @(negedge CLK);
    s_valid = 1'b0;
    chk({tag, "_lat"},  32'(s_oqv),  32'd0);
    chk({tag, "_busy"}, 32'(s_busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk({tag, "_oq"},    32'(s_oq),  32'(seq[7-i]));
      chk({tag, "_valid"}, 32'(s_oqv), 32'd1);
      chk({tag, "_tq"},    32'(s_tq),  32'd0);
    end
    @(negedge CLK);
    chk({tag, "_end_valid"}, 32'(s_oqv),  32'd0);
    chk({tag, "_end_tq"},    32'(s_tq),   32'd1);
    chk({tag, "_end_oq"},    32'(s_oq),   32'd0);
    chk({tag, "_end_busy"},  32'(s_busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq;
  } vec_t;

  typedef struct {
    logic [1:0] w;
    logic [1:0] e;
  } bvec_t;

  vec_t       vecs [4];
  bvec_t      bv   [16];
  logic [3:0] dexp [8];
  logic [7:0] sb   [$];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    s_valid = 1'b0; s_data = '0;
    d_valid = 1'b0; d_data = '0;
    b_valid = 1'b0; b_data = '0;

    vecs[0] = '{8'hA5, 8'b10100101};
    vecs[1] = '{8'h01, 8'b10000000};
    vecs[2] = '{8'hC8, 8'b00010011};
    vecs[3] = '{8'h3E, 8'b01111100};
    dexp[0] = 4'b0011; dexp[1] = 4'b0011; dexp[2] = 4'b1100; dexp[3] = 4'b1100;
    dexp[4] = 4'b1100; dexp[5] = 4'b0011; dexp[6] = 4'b0011; dexp[7] = 4'b1100;
    for (int i = 0; i < 16; i++) begin
      bv[i].w = 2'(i);
      bv[i].e = {bv[i].w[0], bv[i].w[1]};
    end

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_oq",    32'(s_oq),    32'd0);
    chk("rst_valid", 32'(s_oqv),   32'd0);
    chk("rst_tq",    32'(s_tq),    32'd1);
    chk("rst_busy",  32'(s_busy),  32'd0);
    chk("rst_d_oq",  32'(d_oq),    32'hF);
    chk("rst_d_tq",  32'(d_tq),    32'd1);
    chk("rst_d_busy",32'(d_busy),  32'd0);

    // SDR single words
    for (int v = 0; v < 4; v++) send_sdr("sdr", vecs[v].word, vecs[v].seq);

    // DDR back-to-back, two lanes
    @(negedge CLK);
    d_valid = 1'b1;
    d_data  = 16'h0FF0;
    @(negedge CLK);
    chk("ddr_ready_take", 32'(d_ready), 32'd1);
    d_data = 16'hC33C;
    @(negedge CLK);
    d_valid = 1'b0;
    chk("ddr_ready_full", 32'(d_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge CLK);
      chk("ddr_oq",    32'(d_oq),  32'(dexp[i]));
      chk("ddr_valid", 32'(d_oqv), 32'd1);
      chk("ddr_tq",    32'(d_tq),  32'd0);
    end
    @(negedge CLK);
    chk("ddr_end_valid", 32'(d_oqv), 32'd0);
    chk("ddr_end_oq",    32'(d_oq),  32'hF);
    chk("ddr_end_tq",    32'(d_tq),  32'd1);

    // BEATS=1: one word per cycle, no gaps
    for (int n = 0; n < 19; n++) begin
      @(negedge CLK);
      if (n >= 2 && n <= 17) begin
        chk("b1_oq",    32'(b_oq),  32'(bv[n-2].e));
        chk("b1_valid", 32'(b_oqv), 32'd1);
      end else begin
        chk("b1_valid_idle", 32'(b_oqv), 32'd0);
      end
      if (n < 16) begin
        chk("b1_ready", 32'(b_ready), 32'd1);
        b_valid = 1'b1;
        b_data  = bv[n].w;
      end else begin
        b_valid = 1'b0;
      end
    end
    chk("b1_end_busy", 32'(b_busy), 32'd0);

    // Backpressure scoreboard, in_valid held high
    begin : bp
      int         sent, got, bitn, last_cyc;
      bit         took;
      logic [7:0] asm_w, exp_w;
      sent = 0; got = 0; bitn = 0; last_cyc = 0; took = 1'b0; asm_w = '0;
      s_data = 8'($urandom);
      for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
        @(negedge CLK);
        if (s_oqv) begin
          asm_w[bitn] = s_oq[0];
          bitn++;
          if (bitn == 8) begin
            bitn = 0;
            got++;
            if (sb.size() == 0) chk("bp_extra_word", 32'(asm_w), 32'hFFFF_FFFF);
            else begin
              exp_w = sb.pop_front();
              chk("bp_word", 32'(asm_w), 32'(exp_w));
            end
          end
        end
        if (took) s_data = 8'($urandom);
        took    = 1'b0;
        s_valid = (sent < 100);
        if (s_valid && s_ready) begin
          sb.push_back(s_data);
          took = 1'b1;
          if (sent >= 2) chk("bp_ready_interval", 32'(cyc - last_cyc), 32'd8);
          last_cyc = cyc;
          sent++;
        end
      end
      s_valid = 1'b0;
      chk("bp_sent",     32'(sent),      32'd100);
      chk("bp_got",      32'(got),       32'd100);
      chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    end
    repeat (2) @(negedge CLK);

    // Asynchronous reset during the third beat of 8'hFF
    @(negedge CLK);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    @(negedge CLK);
    s_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_mid_pre_oq",    32'(s_oq),  32'd1);
    chk("rst_mid_pre_valid", 32'(s_oqv), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_oq",    32'(s_oq),   32'd0);
    chk("rst_mid_valid", 32'(s_oqv),  32'd0);
    chk("rst_mid_tq",    32'(s_tq),   32'd1);
    chk("rst_mid_busy",  32'(s_busy), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    send_sdr("rst_after", 8'h01, 8'b10000000);

`ifdef SERDES_TX_TRAIN_EN
    begin : train_t
      logic [7:0] pat;
      logic [7:0] w01;
      pat = 8'hB8;
      w01 = 8'h01;
      @(negedge CLK);
      s_train = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(negedge CLK);
        chk("tr_oq",    32'(s_oq),  32'(pat[i%8]));
        chk("tr_valid", 32'(s_oqv), 32'd0);
        chk("tr_tq",    32'(s_tq),  32'd0);
      end
      @(negedge CLK);
      chk("tr_oq", 32'(s_oq), 32'(pat[0]));
      s_valid = 1'b1;
      s_data  = w01;
      @(negedge CLK);
      s_valid = 1'b0;
      s_train = 1'b0;
      for (int i = 1; i < 8; i++) begin
        if (i > 1) @(negedge CLK);
        chk("tr_wait_oq",    32'(s_oq),  32'(pat[i]));
        chk("tr_wait_valid", 32'(s_oqv), 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
        @(negedge CLK);
        chk("tr_word_oq",    32'(s_oq),  32'(w01[i]));
        chk("tr_word_valid", 32'(s_oqv), 32'd1);
      end
      @(negedge CLK);
      chk("tr_end_valid", 32'(s_oqv), 32'd0);
      chk("tr_end_tq",    32'(s_tq),  32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serdes_tx_lanes.md
# serdes_tx_lanes

Single-clock, parametrised multi-lane parallel-to-serial transmitter: the generation after the fixed-width OSERDESE2 primitive model in the simulation library. It accepts one LANES×WIDTH word per valid/ready handshake, double-buffers it, and shifts each lane out SDR (1 bit/cycle) or DDR (2 bits/cycle, rise/fall pair for a downstream ODDR). Tristate control and back-to-back streaming without gaps are included. It sits between the CSI/packet framer and the pad-level output registers.

## Interface
Parameters:
- LANES, 2, number of serial lanes (1–8)
- WIDTH, 8, bits per lane per word; must be a multiple of BPC
- DATA_RATE, "DDR", "SDR" gives BPC=1, "DDR" gives BPC=2
- MSB_FIRST, 0, 1: lane bit WIDTH-1 goes out first; 0: bit 0 goes out first
- INIT_OQ, 1'b0, idle level driven on every oq bit
- TRAIN_PATTERN, 8'hB8, per-lane idle word (WIDTH bits); used only with SERDES_TX_TRAIN_EN

Ports:
- CLK  in  1  sole clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  word offered
- in_ready  out  1  word accepted when in_valid & in_ready
- in_data  in  LANES*WIDTH  lane k in bits [k*WIDTH +: WIDTH]
- oq  out  LANES*BPC  lane k in bits [k*BPC +: BPC]; in DDR, bit 0 = rise, bit 1 = fall
- oq_valid  out  1  oq carries data bits this cycle
- tq  out  1  1 = output tristated (idle), 0 = driving
- busy  out  1  hold or shifter occupied
- train_en  in  1  present only with SERDES_TX_TRAIN_EN

## Operation
- BEATS = WIDTH/BPC beats per word; beat counter width $clog2(BEATS) (min 1).
- Hold register (hold_full flag) plus per-lane shift register; FSM states IDLE, SHIFT.
- Accept: in_ready = ~hold_full | take, where take = hold_full & (state==IDLE | last beat this cycle). Combinational in_ready is permitted.
- take: shifter loads hold word; oq/oq_valid registered with first beat; beat counter = 1; state = SHIFT.
- SHIFT: each cycle next BPC bits per lane to oq (in DDR, earlier bit on rise); on last beat with no take, next cycle returns to IDLE.
- Back-to-back: take on last beat → next word's first beat immediately follows, no gap, oq_valid stays 1.
- IDLE: oq = all INIT_OQ, oq_valid=0, tq=1.
- SHIFT: tq=0.
- busy = hold_full | (state==SHIFT).
- Simultaneous accept and take: hold is refilled with the new word; hold_full stays 1.
- BEATS=1 (e.g. WIDTH=2 DDR): every cycle is a last beat; sustains one word/cycle.

## Timing
- Reset values: in_ready=1 once RST deasserts (hold empty); oq=INIT_OQ replicated; oq_valid=0; tq=1; busy=0; state IDLE; counter 0.
- RST mid-word: partial word and hold content discarded, outputs return to reset values asynchronously.
- Latency: word accepted at edge N, hold_full at N; take at edge N+1; first beat on oq after edge N+1. Transfer is in_valid-to-first-beat 2 edges from an idle state.
- Throughput: one word per BEATS cycles sustained.

## Configuration
- SERDES_TX_TRAIN_EN defined: train_en port exists. In IDLE with train_en=1 and hold empty, the shifter continuously repeats TRAIN_PATTERN on every lane, with oq_valid=0 and tq=0. A pending word waits for the pattern word boundary and then follows without a gap. Deasserting train_en finishes the current pattern word.
- Not defined: train_en port is absent; idle behaviour is INIT_OQ with tq=1 only.

## Structure
- serdes_pkg: BPC function of DATA_RATE, state enum (IDLE, SHIFT), lane-slice helper constants.
- Sub-module serdes_lane_shifter (one per lane, generate loop): load, shift, bit-order and DDR pair output. Counter, FSM and handshake live in serdes_tx_lanes.

## Test plan
- SDR, LANES=1, WIDTH=8, MSB_FIRST=0, one word 8'hA5 → oq = 1,0,1,0,0,1,0,1 over 8 cycles, oq_valid=1 for exactly 8 cycles starting 2 edges after accept; tq=0 during those cycles, then idle.
- DDR, LANES=2, WIDTH=8, MSB_FIRST=1, words {8'hF0, 8'h0F} then {8'h3C, 8'hC3} with in_valid held high → 8 contiguous valid cycles, no gap. Lane0 pairs (rise,fall) = (1,1),(1,1),(0,0),(0,0),(0,0),(1,1),(1,1),(0,0).
- Backpressure: in_valid constantly high, WIDTH=8 SDR → in_ready pulses once per 8 cycles after the initial fill; no word is lost or duplicated (scoreboard over 100 random words).
- BEATS=1 (WIDTH=2 DDR): 16 words at 1/cycle → oq_valid solid for 16 cycles, in_ready constantly 1.
- RST asserted on beat 3 of word 8'hFF → oq=INIT_OQ, oq_valid=0, tq=1 immediately. After release, the next word 8'h01 is emitted cleanly.
- With SERDES_TX_TRAIN_EN, train_en=1, TRAIN_PATTERN=8'hB8 → repeating B8 bitstream with tq=0, oq_valid=0. A word inserted mid-pattern starts exactly at the pattern boundary.
